// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator.
// Encodings match the RAM controller ramControl field.
package lsu_pkg;

    typedef enum logic [2:0] {
        CTRL_W  = 3'b000,
        CTRL_B  = 3'b001,
        CTRL_H  = 3'b010,
        CTRL_BU = 3'b101,
        CTRL_HU = 3'b110
    } lsu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    // Stores only take the signed encodings; the controller ignores sign on writes.
    function automatic logic is_legal(input logic [2:0] ctrl, input logic we);
        case (ctrl)
            3'b000, 3'b001, 3'b010: is_legal = 1'b1;
            3'b101, 3'b110:         is_legal = !we;
            default:                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] ctrl, input logic [1:0] a);
        case (ctrl[1:0])
            2'b00:   is_aligned = (a == 2'b00);
            2'b10:   is_aligned = !a[0];
            default: is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a byte-assembled load value.
// Only instantiated when LSU_MISALIGN_SPLIT_EN is defined.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  ctrl,
    output logic [31:0] value
);

    always_comb begin
        value = raw;
        case (ctrl)
            CTRL_B:  value = {{24{raw[7]}}, raw[7:0]};
            CTRL_BU: value = {24'h0, raw[7:0]};
            CTRL_H:  value = {{16{raw[15]}}, raw[15:0]};
            CTRL_HU: value = {16'h0, raw[15:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator driving the byte-lane RAM controller port.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into byte beats.
module lsu_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_ctrl,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_ctrl,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (DATA_W != 32) begin : g_bad_width
        $error("lsu_initiator: DATA_W must be 32");
    end

    lsu_state_e        state;
    logic              we_q;
    logic              err_q;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] load_val;
    logic              legal;
    logic              aligned;

    assign req_ready = (state == IDLE);
    assign legal     = is_legal(req_ctrl, req_we);
    assign aligned   = is_aligned(req_ctrl, req_addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              split_q;
    logic [1:0]        beat_q;
    logic [1:0]        last_q;
    logic [1:0]        beat_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        ctrl_q;
    logic [31:0]       ext;

    assign beat_n = beat_q + 2'd1;

    lsu_load_extend u_ext (
        .raw   (asm_q),
        .ctrl  (ctrl_q),
        .value (ext)
    );

    assign load_val = split_q ? ext : asm_q;
`else
    assign load_val = asm_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            asm_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ctrl  <= 3'b000;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q   <= 1'b0;
            beat_q    <= 2'd0;
            last_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ctrl_q    <= 3'b000;
`endif
        end else begin
            rsp_valid <= 1'b0;
            mem_we    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        // Error requests still dwell one cycle so latency is uniform.
                        state <= ACCESS;
                        we_q  <= req_we;
                        err_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        ctrl_q  <= req_ctrl;
                        split_q <= 1'b0;
                        beat_q  <= 2'd0;
`endif
                        if (!legal) begin
                            err_q <= 1'b1;
                        end else if (aligned) begin
                            mem_addr  <= req_addr;
                            mem_ctrl  <= req_ctrl;
                            mem_wdata <= req_wdata;
                            mem_we    <= req_we;
                        end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
                            split_q   <= 1'b1;
                            last_q    <= req_ctrl[1] ? 2'd1 : 2'd3;
                            mem_addr  <= req_addr;
                            mem_ctrl  <= req_we ? 3'(CTRL_B) : 3'(CTRL_BU);
                            mem_wdata <= {24'h0, req_wdata[7:0]};
                            mem_we    <= req_we;
`else
                            err_q <= 1'b1;
`endif
                        end
                    end
                end
                ACCESS: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        asm_q[{beat_q, 3'b000} +: 8] <= mem_rdata[7:0];
                        if (beat_q == last_q) begin
                            state <= RESP;
                        end else begin
                            beat_q    <= beat_n;
                            mem_addr  <= addr_q + ADDR_W'(beat_n);
                            mem_wdata <= {24'h0, wdata_q[{beat_n, 3'b000} +: 8]};
                            mem_we    <= we_q;
                        end
                    end else begin
                        asm_q <= mem_rdata;
                        state <= RESP;
                    end
`else
                    asm_q <= mem_rdata;
                    state <= RESP;
`endif
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= (err_q || we_q) ? '0 : load_val;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_initiator.sv
// Scoreboard bench for lsu_initiator with a byte-addressed RAM controller model.
module tb_lsu_initiator;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_ctrl = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_rdata;

    lsu_initiator dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ctrl  (mem_ctrl),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM controller model: combinational extended read, byte-lane write on clock edge
    logic [7:0] mem [0:255];
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    assign a0 = mem_addr[7:0];
    assign a1 = 8'(mem_addr[7:0] + 8'd1);
    assign a2 = 8'(mem_addr[7:0] + 8'd2);
    assign a3 = 8'(mem_addr[7:0] + 8'd3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        mem_rdata = '0;
        case (mem_ctrl)
            3'b000: mem_rdata = {b3, b2, b1, b0};
            3'b001: mem_rdata = {{24{b0[7]}}, b0};
            3'b101: mem_rdata = {24'h0, b0};
            3'b010: mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b110: mem_rdata = {16'h0, b1, b0};
            default: mem_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_ctrl)
                3'b000: begin
                    mem[a0] <= mem_wdata[7:0];
                    mem[a1] <= mem_wdata[15:8];
                    mem[a2] <= mem_wdata[23:16];
                    mem[a3] <= mem_wdata[31:24];
                end
                3'b001: mem[a0] <= mem_wdata[7:0];
                3'b010: begin
                    mem[a0] <= mem_wdata[7:0];
                    mem[a1] <= mem_wdata[15:8];
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wb;
        logic [31:0] waddr;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   wcount = 0;
    logic [31:0] last_waddr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) if (reset) wcount = 0;

    // Monitor: count write beats, pop and compare on each response pulse
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) begin
            wcount++;
            last_waddr = mem_addr;
        end
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("write_beats", 32'(wcount), 32'(e.wb));
                if (e.wb > 0) chk("last_write_addr", last_waddr, e.waddr);
            end
            wcount = 0;
        end
    end

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            chk("rsp_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] c, input logic [31:0] er, input logic ee,
                         input int lat, input int wb, input logic [31:0] wa);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            req_valid = 1'b1;
            req_we    = we;
            req_addr  = a;
            req_wdata = d;
            req_ctrl  = c;
            @(posedge clk);
            #1;
            e.rdata = er; e.err = ee; e.lat = lat; e.wb = wb; e.waddr = wa; e.acc = cyc;
            sbq.push_back(e);
            req_valid = 1'b0;
            drain();
        end
    endtask

    initial begin
        int acc_cnt;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_ctrl", {29'd0, mem_ctrl}, 32'd0);
        reset = 1'b0;

        //    we    addr    wdata         ctrl    rdata          err lat wb waddr
        issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 32'h0,         0, 2, 1, 32'h10);
        issue(1'b0, 32'h10, 32'h0,        3'b000, 32'hDEADBEEF,  0, 2, 0, 32'h0);
        issue(1'b1, 32'h13, 32'h0000005A, 3'b001, 32'h0,         0, 2, 1, 32'h13);
        issue(1'b0, 32'h13, 32'h0,        3'b001, 32'h0000005A,  0, 2, 0, 32'h0);
        issue(1'b0, 32'h13, 32'h0,        3'b101, 32'h0000005A,  0, 2, 0, 32'h0);
        issue(1'b1, 32'h13, 32'h00000080, 3'b001, 32'h0,         0, 2, 1, 32'h13);
        issue(1'b0, 32'h13, 32'h0,        3'b001, 32'hFFFFFF80,  0, 2, 0, 32'h0);
        issue(1'b0, 32'h13, 32'h0,        3'b101, 32'h00000080,  0, 2, 0, 32'h0);
        issue(1'b1, 32'h10, 32'h80011234, 3'b000, 32'h0,         0, 2, 1, 32'h10);
        issue(1'b0, 32'h12, 32'h0,        3'b010, 32'hFFFF8001,  0, 2, 0, 32'h0);
        issue(1'b0, 32'h12, 32'h0,        3'b110, 32'h00008001,  0, 2, 0, 32'h0);
        issue(1'b1, 32'h20, 32'h44332211, 3'b000, 32'h0,         0, 2, 1, 32'h20);
        issue(1'b1, 32'h24, 32'h88776655, 3'b000, 32'h0,         0, 2, 1, 32'h24);

        // Misaligned accesses: split into byte beats or rejected
        issue(1'b0, 32'h21, 32'h0, 3'b000, SPLIT ? 32'h55443322 : 32'h0,
              !SPLIT, SPLIT ? 5 : 2, 0, 32'h0);
        issue(1'b0, 32'h23, 32'h0, 3'b010, SPLIT ? 32'h00005544 : 32'h0,
              !SPLIT, SPLIT ? 3 : 2, 0, 32'h0);
        issue(1'b1, 32'h25, 32'h0000AABB, 3'b010, 32'h0,
              !SPLIT, SPLIT ? 3 : 2, SPLIT ? 2 : 0, 32'h26);
        issue(1'b0, 32'h26, 32'h0, 3'b110, SPLIT ? 32'h000088AA : 32'h00008877,
              0, 2, 0, 32'h0);
        issue(1'b0, 32'h26, 32'h0, 3'b010, SPLIT ? 32'hFFFF88AA : 32'hFFFF8877,
              0, 2, 0, 32'h0);

        // Illegal encodings never reach memory
        issue(1'b1, 32'h10, 32'h000000FF, 3'b101, 32'h0, 1, 2, 0, 32'h0);
        issue(1'b1, 32'h10, 32'h0000FFFF, 3'b110, 32'h0, 1, 2, 0, 32'h0);
        issue(1'b0, 32'h10, 32'h0,        3'b011, 32'h0, 1, 2, 0, 32'h0);
        issue(1'b0, 32'h10, 32'h0,        3'b000, 32'h80011234, 0, 2, 0, 32'h0);

        // Reset during the ACCESS cycle of a store
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_ctrl  = 3'b000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_access_we", {31'd0, mem_we}, 32'd1);
        chk("mid_rst_access_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Back-to-back: request held high for nine edges
        acc_cnt = 0;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_ctrl  = 3'b000;
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (req_ready) begin
                exp_t e;
                e.rdata = 32'h80011234; e.err = 1'b0; e.lat = 2;
                e.wb = 0; e.waddr = '0; e.acc = cyc + 1;
                sbq.push_back(e);
                acc_cnt++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt), 32'd3);
        drain();

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
